// File: rtl/turn_signal_conditioner.sv
// Input conditioner for the tail-light sequencer: synchronises, debounces and edge-detects the
// left/right/hazard controls, then latches presses into held turn/hazard request levels.
module turn_signal_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18,
  parameter int unsigned LATCH_MODE      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic left_btn,
  input  logic right_btn,
  input  logic hazard_btn,
  output logic left,
  output logic right,
  output logic left_press,
  output logic right_press,
  output logic hazard_press
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel bit order throughout: 0 = left, 1 = right, 2 = hazard.
  localparam int unsigned ChLeft   = 0;
  localparam int unsigned ChRight  = 1;
  localparam int unsigned ChHazard = 2;

  typedef enum logic [1:0] {StIdle, StLeftOn, StRightOn, StHazard} state_e;

  logic [2:0]       raw;
  logic [2:0]       sync_meta_q;
  logic [2:0]       sync_q;
  logic [2:0]       stable_q;
  logic [2:0]       stable_dly_q;
  logic [2:0]       press_q;
  logic [CNT_W-1:0] cnt_q [3];
  state_e           state_q;
  state_e           state_d;

  assign raw = {hazard_btn, right_btn, left_btn};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta_q  <= '0;
      sync_q       <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync_meta_q  <= raw;
      sync_q       <= sync_meta_q;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
      // Any agreement restarts the count, so only an unbroken disagreement run flips the level.
      for (int i = 0; i < 3; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          stable_q[i] <= sync_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (LATCH_MODE == 0) begin
      state_d = StIdle;
    end else if (press_q[ChHazard]) begin
      state_d = (state_q == StHazard) ? StIdle : StHazard;
    end else if (press_q[ChLeft] && !press_q[ChRight]) begin
      unique case (state_q)
        StIdle:    state_d = StLeftOn;
        StLeftOn:  state_d = StIdle;
        StRightOn: state_d = StLeftOn;
        StHazard:  state_d = StHazard;
        default:   state_d = StIdle;
      endcase
    end else if (press_q[ChRight] && !press_q[ChLeft]) begin
      unique case (state_q)
        StIdle:    state_d = StRightOn;
        StRightOn: state_d = StIdle;
        StLeftOn:  state_d = StRightOn;
        StHazard:  state_d = StHazard;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      left    <= 1'b0;
      right   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (LATCH_MODE != 0) begin
        left  <= (state_d == StLeftOn) || (state_d == StHazard);
        right <= (state_d == StRightOn) || (state_d == StHazard);
      end else begin
        left  <= stable_q[ChLeft] | stable_q[ChHazard];
        right <= stable_q[ChRight] | stable_q[ChHazard];
      end
    end
  end

  assign left_press   = press_q[ChLeft];
  assign right_press  = press_q[ChRight];
  assign hazard_press = press_q[ChHazard];

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Bench for turn_signal_conditioner: latched and follow-mode instances share stimulus and are
// compared against a history-window debounce model plus a press-driven state table.
module tb_turn_signal_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_btn = 1'b0;
  logic right_btn = 1'b0;
  logic hazard_btn = 1'b0;
  logic left, right, left_press, right_press, hazard_press;
  logic left0, right0, left_press0, right_press0, hazard_press0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  turn_signal_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .LATCH_MODE(1)) dut (
    .clk(clk), .reset(reset), .left_btn(left_btn), .right_btn(right_btn),
    .hazard_btn(hazard_btn), .left(left), .right(right), .left_press(left_press),
    .right_press(right_press), .hazard_press(hazard_press)
  );

  turn_signal_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .LATCH_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .left_btn(left_btn), .right_btn(right_btn),
    .hazard_btn(hazard_btn), .left(left0), .right(right0), .left_press(left_press0),
    .right_press(right_press0), .hazard_press(hazard_press0)
  );

  logic [9:0] obs;
  assign obs = {left, right, left_press, right_press, hazard_press,
                left0, right0, left_press0, right_press0, hazard_press0};

  // Model: raw samples logged per edge; a level flips once the last 4 synced samples all disagree.
  int       e = 0;
  int       rst_edge = 0;
  bit       raw_log [3][8192];
  bit [2:0] m_stable = '0, m_stable_d = '0, m_press = '0;
  int       m_state = 0;  // 0 idle, 1 left, 2 right, 3 hazard
  bit       m_left = 0, m_right = 0, m_left0 = 0, m_right0 = 0;

  function automatic bit sync_at(int ch, int m);
    if (m - 2 > rst_edge) return raw_log[ch][m-2];
    return 1'b0;
  endfunction

  function automatic int fsm_next(int s, bit [2:0] p);
    if (p[2]) return (s == 3) ? 0 : 3;
    if (p[0] && !p[1]) return (s == 0) ? 1 : (s == 1) ? 0 : (s == 2) ? 1 : 3;
    if (p[1] && !p[0]) return (s == 0) ? 2 : (s == 2) ? 0 : (s == 1) ? 2 : 3;
    return s;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m_left, m_right, m_press[0], m_press[1], m_press[2],
            m_left0, m_right0, m_press[0], m_press[1], m_press[2]};
  endfunction

  task automatic step();
    bit [2:0] rawv;
    bit       rs;
    bit [2:0] nstable;
    bit       flip;
    rawv = {hazard_btn, right_btn, left_btn};
    rs   = reset;
    @(posedge clk);
    e++;
    for (int ch = 0; ch < 3; ch++) raw_log[ch][e] = rawv[ch];
    if (rs) begin
      rst_edge = e;
      m_stable = '0; m_stable_d = '0; m_press = '0; m_state = 0;
      m_left = 0; m_right = 0; m_left0 = 0; m_right0 = 0;
    end else begin
      nstable = m_stable;
      for (int ch = 0; ch < 3; ch++) begin
        flip = (e - 3 > rst_edge);
        for (int k = 0; k < 4; k++) if (sync_at(ch, e - k) == m_stable[ch]) flip = 0;
        if (flip) nstable[ch] = ~m_stable[ch];
      end
      m_left0    = m_stable[0] | m_stable[2];
      m_right0   = m_stable[1] | m_stable[2];
      m_state    = fsm_next(m_state, m_press);
      m_press    = m_stable & ~m_stable_d;
      m_stable_d = m_stable;
      m_stable   = nstable;
      m_left     = (m_state == 1) || (m_state == 3);
      m_right    = (m_state == 2) || (m_state == 3);
    end
    #1;
  endtask

  // Holds button pattern for 'hold' cycles, then releases and runs to 'total' cycles.
  task automatic drive(bit [2:0] btns, int hold, int total);
    {hazard_btn, right_btn, left_btn} = btns;
    for (int i = 0; i < total; i++) begin
      if (i == hold) {hazard_btn, right_btn, left_btn} = 3'b000;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {hazard_btn, right_btn, left_btn} = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== 10'b0) begin
        errors++;
        $display("FAIL reset_hold: outputs %b, required %b", obs, 10'b0);
      end
    end
    reset = 1'b0;
    {hazard_btn, right_btn, left_btn} = 3'b000;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (obs !== 10'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_release: outputs %b, required %b", obs, 10'b0);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 40; i++) begin
      left_btn = (i < 30) ? ((i / 2) % 2 == 0) : 1'b0;
      step();
      checks++;
      if (left_press !== 1'b0 || left !== 1'b0 || left0 !== 1'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL bounce: outputs %b, model %b, left/left_press/left0 must stay 0",
                 obs, exp_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    left_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (left_press !== (k == 7) || left !== (k >= 8) || left0 !== (k >= 7)) begin
        errors++;
        $display("FAIL clean_press edge %0d: press=%b left=%b left0=%b, required %b %b %b",
                 k, left_press, left, left0, k == 7, k >= 8, k >= 7);
      end
    end
    left_btn = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (left !== 1'b1 || left_press !== 1'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL clean_release edge %0d: outputs %b, model %b", k, obs, exp_vec());
      end
    end
    checks++;
    if (left0 !== 1'b0) begin
      errors++;
      $display("FAIL follow_release: left0 %b, required 0", left0);
    end
  endtask

  task automatic test_switch();
    drive(3'b010, 8, 14);
    checks++;
    if ({left, right} !== 2'b01 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL switch: left,right %b%b, required 01 (model %b)", left, right, exp_vec());
    end
    drive(3'b010, 8, 14);
    checks++;
    if ({left, right} !== 2'b00 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL cancel: left,right %b%b, required 00 (model %b)", left, right, exp_vec());
    end
  endtask

  task automatic test_priority();
    drive(3'b101, 8, 14);
    checks++;
    if ({left, right} !== 2'b11) begin
      errors++;
      $display("FAIL hazard_enter: left,right %b%b, required 11", left, right);
    end
    drive(3'b001, 8, 14);
    checks++;
    if ({left, right} !== 2'b11) begin
      errors++;
      $display("FAIL hazard_ignore_left: left,right %b%b, required 11", left, right);
    end
    drive(3'b100, 8, 14);
    checks++;
    if ({left, right} !== 2'b00) begin
      errors++;
      $display("FAIL hazard_exit: left,right %b%b, required 00", left, right);
    end
    drive(3'b011, 8, 14);
    checks++;
    if ({left, right} !== 2'b00 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL dual_press: left,right %b%b, required 00", left, right);
    end
  endtask

  task automatic test_reset_mid_debounce();
    left_btn = 1'b1;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (left !== (k >= 8) || left0 !== (k >= 7) || left_press !== (k == 7)) begin
        errors++;
        $display("FAIL reset_mid edge %0d: left=%b left0=%b press=%b, required %b %b %b",
                 k, left, left0, left_press, k >= 8, k >= 7, k == 7);
      end
    end
    left_btn = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 400; seg++) begin
      {hazard_btn, right_btn, left_btn} = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 49) == 0);
      hold  = reset ? 1 : int'($urandom_range(1, 9));
      for (int i = 0; i < hold; i++) begin
        step();
        reset = 1'b0;
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL random seg %0d: outputs %b, model %b", seg, obs, exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_switch();
    test_priority();
    test_reset_mid_debounce();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
